// File: rtl/mult_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
//   OPW_DEF   : default operand width
//   PW_DEF    : default product width (2 * OPW_DEF)
//   state_t   : controller state encoding
//   cnt_width : width of the Booth step counter for a given operand width
package mult_pkg;

  localparam int unsigned OPW_DEF = 9;
  localparam int unsigned PW_DEF  = 2 * OPW_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned opw);
    return $clog2(opw + 1);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of the
// multiplicand into the accumulator followed by an arithmetic right shift
// of {acc, q, qm1}.
// Ports:
//   acc, q, qm1 : current accumulator, multiplier register, Q(-1) bit
//   m           : sign-extended multiplicand (OPW+1 bits)
//   acc_nxt, q_nxt, qm1_nxt : shifted result
module booth_step #(
  parameter int unsigned OPW = 9
) (
  input  logic [OPW:0]   acc,
  input  logic [OPW-1:0] q,
  input  logic           qm1,
  input  logic [OPW:0]   m,
  output logic [OPW:0]   acc_nxt,
  output logic [OPW-1:0] q_nxt,
  output logic           qm1_nxt
);

  logic [OPW:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], qm1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_nxt = {sum[OPW], sum[OPW:1]};
    q_nxt   = {sum[0], q[OPW-1:1]};
    qm1_nxt = q[0];
  end

endmodule

// File: rtl/mult9_booth_seq.sv
// Sequential two's-complement multiplier, one radix-2 Booth step per cycle.
// Operands are accepted in IDLE, OPW steps run in RUN, the product is held
// in DONE until out_ready.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (A, B)
//   out_valid/ out_ready: product handshake (P)
//   A, B                : OPW-bit two's-complement operands
//   P                   : 2*OPW-bit two's-complement product
// Optional build macro: MULT9_ZERO_SKIP_EN -- a zero operand completes after
// a single cycle instead of OPW cycles.
module mult9_booth_seq
  import mult_pkg::*;
#(
  parameter int unsigned OPW = OPW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPW-1:0]    A,
  input  logic [OPW-1:0]    B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OPW-1:0]  P
);

  localparam int unsigned CW = cnt_width(OPW);
  localparam logic [CW-1:0] LAST = CW'(OPW - 1);

  state_t         state_q, state_d;
  logic [OPW:0]   acc_q, acc_d;
  logic [OPW-1:0] q_q, q_d;
  logic           qm1_q, qm1_d;
  logic [OPW:0]   m_q, m_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [OPW:0]   acc_s;
  logic [OPW-1:0] q_s;
  logic           qm1_s;

  booth_step #(
    .OPW (OPW)
  ) u_step (
    .acc     (acc_q),
    .q       (q_q),
    .qm1     (qm1_q),
    .m       (m_q),
    .acc_nxt (acc_s),
    .q_nxt   (q_s),
    .qm1_nxt (qm1_s)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = {A[OPW-1], A};
          q_d     = B;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef MULT9_ZERO_SKIP_EN
          // Zero the multiplier and jump to the last step: one no-op Booth
          // step on all-zero state lands in DONE with P=0 after one cycle.
          if (A == '0 || B == '0) begin
            q_d   = '0;
            cnt_d = LAST;
          end
`endif
        end
      end
      RUN: begin
        acc_d = acc_s;
        q_d   = q_s;
        qm1_d = qm1_s;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  // Product is the low 2*OPW bits of {acc, q}; acc's top bit is only guard.
  assign P         = {acc_q[OPW-1:0], q_q};

endmodule

// File: tb/tb_mult9_booth_seq.sv
module tb_mult9_booth_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  A;
  logic [8:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] P;

  int n_checks = 0;
  int n_pass   = 0;

  mult9_booth_seq #(
    .OPW (9)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: signed integer product truncated to 18 bits.
  function automatic logic [17:0] model(input logic [8:0] a, input logic [8:0] b);
    int sa, sb, pr;
    sa = $signed(a);
    sb = $signed(b);
    pr = sa * sb;
    return pr[17:0];
  endfunction

  function automatic int exp_lat(input logic [8:0] a, input logic [8:0] b);
`ifdef MULT9_ZERO_SKIP_EN
    if (a == 9'd0 || b == 9'd0) return 1;
`endif
    return 9;
  endfunction

  // Called at the negedge just after the accepting edge.
  task automatic finish_op(input logic [17:0] exp, input int elat, input int bp,
                           input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/lat"}, lat, elat);
    check({tag, "/P"}, P, exp);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, out_valid, 1'b1);
      check({tag, "/hold_P"}, P, exp);
      check({tag, "/hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/idle_valid"}, out_valid, 1'b0);
    check({tag, "/idle_ready"}, in_ready, 1'b1);
  endtask

  task automatic run_op(input logic [8:0] a, input logic [8:0] b, input int bp,
                        input string tag);
    check({tag, "/ready"}, in_ready, 1'b1);
    A         = a;
    B         = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A        = 9'($urandom);
    B        = 9'($urandom);
    check({tag, "/busy"}, in_ready, 1'b0);
    finish_op(model(a, b), exp_lat(a, b), bp, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    repeat (2) @(negedge clk);
    check("rst/in_ready", in_ready, 1'b1);
    check("rst/out_valid", out_valid, 1'b0);
    check("rst/P", P, 18'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corners
    run_op(9'h0FF, 9'h0FF, 0, "ff_ff");
    check("ff_ff/const", model(9'h0FF, 9'h0FF), 18'h0FE01);
    run_op(9'h100, 9'h100, 0, "min_min");
    run_op(9'h100, 9'h0FF, 0, "min_ff");
    run_op(9'h1FF, 9'h1FF, 0, "m1_m1");
    run_op(9'h0FF, 9'h0FF, 5, "backpressure");
    run_op(9'h000, 9'h07F, 0, "zero_a");
    run_op(9'h07F, 9'h000, 1, "zero_b");

    // Reset in the middle of an operation
    A = 9'h0FF; B = 9'h0FF; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst/in_ready", in_ready, 1'b1);
    check("midrst/out_valid", out_valid, 1'b0);
    check("midrst/P", P, 18'h0);
    rst_n = 1'b1;
    run_op(9'h003, 9'h1FE, 0, "after_rst");

    // Operand presented during reset is taken on the first released edge
    rst_n = 1'b0; A = 9'h005; B = 9'h007; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstacc/held_idle", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("rstacc/accepted", in_ready, 1'b0);
    finish_op(model(9'h005, 9'h007), 9, 0, "rstacc");

    // Back-to-back with in_valid held and out_ready held high
    out_ready = 1'b1;
    A = 9'h123; B = 9'h045; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    A = 9'h1A5; B = 9'h0C3;
    check("b2b/busy", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b/lat1", lat, 9);
    check("b2b/P1", P, model(9'h123, 9'h045));
    @(posedge clk);
    @(negedge clk);
    check("b2b/no_accept_on_handshake", in_ready, 1'b1);
    check("b2b/valid_drop", out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b/accept2", in_ready, 1'b0);
    finish_op(model(9'h1A5, 9'h0C3), 9, 0, "b2b2");

    // Random operands with random backpressure
    for (int i = 0; i < 40; i++) begin
      logic [8:0] ra, rb;
      ra = 9'($urandom);
      rb = 9'($urandom);
      if (i % 10 == 0) ra = 9'h000;
      run_op(ra, rb, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
